// File: rtl/result_collector_pkg.sv
// Shared types and width helpers for the result collector.
// Elements are 2*DATA_WIDTH wide and biases DATA_WIDTH wide.
package result_collector_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int ERR_CNT_W = 8;
    localparam int VEC_CNT_W = 16;

    function automatic int result_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Keep address ports at least one bit wide, even for LENGTH == 1.
    function automatic int addr_width(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Element stream, flush and bias-write bus into the collector, plus its result outputs.
// valid/ready: there is no backpressure; in_valid is taken on every rising clk edge unless flush is high.
// ready is an output-only pulse marking a fresh input_data.
interface result_collector_if
    import result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 10
) ();
    localparam int RW = result_width(DATA_WIDTH);
    localparam int AW = addr_width(LENGTH);

    logic                         in_valid;
    logic [RW-1:0]                in_data;
    logic                         in_last;
    logic                         flush;
    logic                         bias_we;
    logic [AW-1:0]                bias_addr;
    logic [DATA_WIDTH-1:0]        bias_wdata;
    logic [RW*LENGTH-1:0]         input_data;
    logic [DATA_WIDTH*LENGTH-1:0] biases;
    logic                         ready;
    logic [ERR_CNT_W-1:0]         err_cnt;
    logic [VEC_CNT_W-1:0]         vec_cnt;
    state_e                       dbg_state;
    logic [AW-1:0]                dbg_idx;

    modport master (
        output in_valid, in_data, in_last, flush, bias_we, bias_addr, bias_wdata,
        input  input_data, biases, ready, err_cnt, vec_cnt, dbg_state, dbg_idx
    );

    modport slave (
        input  in_valid, in_data, in_last, flush, bias_we, bias_addr, bias_wdata,
        output input_data, biases, ready, err_cnt, vec_cnt, dbg_state, dbg_idx
    );
endinterface

// File: rtl/collector_bias_rf.sv
// Bias register file: LENGTH x DATA_WIDTH, one write port, every entry readable in parallel.
// Writes to addresses at or above LENGTH are dropped.
module collector_bias_rf
    import result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we_i,
    input  logic [addr_width(LENGTH)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH*LENGTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [LENGTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LENGTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (we_i && (int'(addr_i) < LENGTH)) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_rd
        assign rdata_o[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
    end
endmodule

// File: rtl/result_collector.sv
// Collects LENGTH signed column results into a shadow vector and publishes it whole,
// with framing-error detection, flush, and a bias register file alongside.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 10
) (
    input  logic             clk,
    input  logic             reset,
    result_collector_if.slave bus
);
    localparam int RW = result_width(DATA_WIDTH);
    localparam int AW = addr_width(LENGTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(LENGTH - 1);

    state_e                state_q;
    logic [AW-1:0]         idx_q;
    logic [RW*LENGTH-1:0]  shadow_q;
    logic [RW*LENGTH-1:0]  input_data_q;
    logic [RW*LENGTH-1:0]  assembled_d;
    logic                  ready_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [VEC_CNT_W-1:0]  vec_cnt_q;

    // The final element bypasses the shadow so the whole vector lands on one edge.
    always_comb begin
        assembled_d = shadow_q;
        assembled_d[(LENGTH-1)*RW +: RW] = bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            input_data_q <= '0;
            ready_q      <= 1'b0;
            err_cnt_q    <= '0;
            vec_cnt_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            if (bus.flush) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else if (bus.in_valid) begin
                shadow_q[int'(idx_q)*RW +: RW] <= bus.in_data;
                if ((idx_q == LAST_IDX) && bus.in_last) begin
                    input_data_q <= assembled_d;
                    ready_q      <= 1'b1;
                    vec_cnt_q    <= vec_cnt_q + 1'b1;
                    state_q      <= IDLE;
                    idx_q        <= '0;
                end else if ((idx_q == LAST_IDX) || bus.in_last) begin
                    // Early or missing in_last: the partial vector is thrown away.
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    state_q <= IDLE;
                    idx_q   <= '0;
                end else begin
                    state_q <= FILL;
                    idx_q   <= idx_q + 1'b1;
                end
            end
        end
    end

    collector_bias_rf #(
        .DATA_WIDTH(DATA_WIDTH),
        .LENGTH    (LENGTH)
    ) u_bias_rf (
        .clk    (clk),
        .reset  (reset),
        .we_i   (bus.bias_we),
        .addr_i (bus.bias_addr),
        .wdata_i(bus.bias_wdata),
        .rdata_o(bus.biases)
    );

    assign bus.input_data = input_data_q;
    assign bus.ready      = ready_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.vec_cnt    = vec_cnt_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_idx    = idx_q;
endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios plus random traffic, checked every cycle
// against a queue-based vector model and a bias array.
module tb_result_collector;
    import result_collector_pkg::*;

    localparam int DW  = 8;
    localparam int LEN = 10;
    localparam int RW  = 2 * DW;
    localparam int VW  = RW * LEN;

    logic clk = 1'b0;
    logic reset;

    result_collector_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) bus ();

    result_collector #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [VW-1:0] exp_q[$];
    logic [RW-1:0] cur_q[$];
    logic [VW-1:0] last_vec;
    logic [DW-1:0] bias_m[LEN];
    int            exp_err;
    int            exp_vec;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW*LEN-1:0] bias_vec();
        logic [DW*LEN-1:0] v;
        for (int k = 0; k < LEN; k++) v[k*DW +: DW] = bias_m[k];
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur_q.delete();
        last_vec = '0;
        exp_err  = 0;
        exp_vec  = 0;
        for (int k = 0; k < LEN; k++) bias_m[k] = '0;
    endtask

    // Applies the effect of the edge that just passed, using the inputs that were held across it.
    task automatic model_step();
        logic [VW-1:0] v;
        if (bus.bias_we && int'(bus.bias_addr) < LEN) bias_m[bus.bias_addr] = bus.bias_wdata;
        if (bus.flush) begin
            cur_q.delete();
        end else if (bus.in_valid) begin
            cur_q.push_back(bus.in_data);
            if (bus.in_last && cur_q.size() == LEN) begin
                v = '0;
                for (int k = 0; k < LEN; k++) v[k*RW +: RW] = cur_q[k];
                exp_q.push_back(v);
                exp_vec = (exp_vec + 1) % 65536;
                cur_q.delete();
            end else if (bus.in_last || cur_q.size() == LEN) begin
                if (exp_err < 255) exp_err++;
                cur_q.delete();
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_ready;
        exp_ready = 1'b0;
        if (exp_q.size() > 0) begin
            last_vec  = exp_q.pop_front();
            exp_ready = 1'b1;
        end
        chk("ready", bus.ready, exp_ready);
        chk("input_data", bus.input_data, last_vec);
        chk("err_cnt", bus.err_cnt, exp_err);
        chk("vec_cnt", bus.vec_cnt, exp_vec);
        chk("biases", bus.biases, bias_vec());
    endtask

    task automatic cycle(input logic v, input logic [RW-1:0] d, input logic l, input logic f);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.flush    = f;
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        check_outputs();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.flush    = 1'b0;
        bus.bias_we  = 1'b0;
    endtask

    task automatic bias_write(input int addr, input logic [DW-1:0] data);
        bus.bias_we    = 1'b1;
        bus.bias_addr  = 4'(addr);
        bus.bias_wdata = data;
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_vec(input logic [RW-1:0] base, input logic [RW-1:0] step);
        for (int i = 0; i < LEN; i++) cycle(1'b1, base + RW'(i) * step, i == LEN - 1, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.flush      = 1'b0;
        bus.bias_we    = 1'b0;
        bus.bias_addr  = '0;
        bus.bias_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        chk("reset_state", bus.dbg_state, IDLE);
        reset = 1'b0;

        // Elements 1..10, last on the 10th.
        send_vec(16'd1, 16'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Back-to-back: -5 x10 then 0x7FFF x10.
        send_vec(16'hFFFB, 16'd0);
        send_vec(16'h7FFF, 16'd0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Early in_last on element 4, then a clean vector.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(100 + i), i == 3, 1'b0);
        send_vec(16'h0200, 16'd3);

        // Missing in_last on element 10, then a clean vector.
        for (int i = 0; i < LEN; i++) cycle(1'b1, 16'(50 + i), 1'b0, 1'b0);
        send_vec(16'h8000, 16'd1);

        // Flush coincident with a 7th element, then A0..A9.
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'(i + 1), 1'b0, 1'b0);
        cycle(1'b1, 16'h0077, 1'b0, 1'b1);
        send_vec(16'h00A0, 16'd1);

        // Bias writes to 0..9 plus an out-of-range address.
        for (int a = 0; a < LEN; a++) bias_write(a, 8'(8'hF0 + a));
        bias_write(12, 8'h5A);
        chk("bias_slot0", bus.biases[7:0], 8'hF0);

        // Random traffic with flushes, framing errors and bias writes.
        for (int c = 0; c < 600; c++) begin
            logic v, l, f;
            v = ($urandom_range(0, 9) < 8);
            if (cur_q.size() == LEN - 1) l = ($urandom_range(0, 9) < 9);
            else l = ($urandom_range(0, 99) < 4);
            f = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) begin
                bus.bias_we    = 1'b1;
                bus.bias_addr  = 4'($urandom_range(0, 15));
                bus.bias_wdata = 8'($urandom);
            end
            cycle(v, 16'($urandom), l, f);
        end

        // Asynchronous reset in the middle of a vector.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(i + 9), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("async_idx", bus.dbg_idx, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_vec(16'h0300, 16'd7);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Drive the error counter into saturation.
        for (int i = 0; i < 260; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        chk("err_sat", bus.err_cnt, 255);
        send_vec(16'h1234, 16'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
